// File: rtl/mem_stage.sv
// Memory-access stage: store interface, address checks, load extension and M/W register.
module mem_stage #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DM_END   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ins,
    input  logic [31:0] M_alu_res,
    input  logic [31:0] M_mlu_res,
    input  logic [31:0] M_rt_data,
    input  logic        M_ov,
    input  logic [31:0] M_cp0_rd,
    input  logic        req,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [4:0]  M_excode,
    output logic [31:0] W_PC,
    output logic [31:0] W_ins,
    output logic [31:0] W_alu_res,
    output logic [31:0] W_mlu_res,
    output logic [31:0] W_mem_read,
    output logic [31:0] W_cp0_rd
);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam int unsigned TC_WIN = 12;
    localparam int unsigned IG_WIN = 4;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    logic [5:0]  op;
    logic [1:0]  off;
    logic [31:0] tc0_off, tc1_off, ig_off, dm_off;
    logic        is_load, is_store, is_word, is_half;
    logic        in_dm, in_tc0, in_tc1, in_ig, in_timer, valid_addr, tc_count;
    logic        misaligned, adel, ades;
    logic [31:0] ext_data;

    logic [31:0] w_pc_q, w_pc_d;
    logic [31:0] w_ins_q, w_ins_d;
    logic [31:0] w_alu_q, w_alu_d;
    logic [31:0] w_mlu_q, w_mlu_d;
    logic [31:0] w_mem_q, w_mem_d;
    logic [31:0] w_cp0_q, w_cp0_d;

    assign op  = M_ins[31:26];
    assign off = M_alu_res[1:0];

    assign is_load  = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                      (op == OP_LB) || (op == OP_LBU);
    assign is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    assign is_word  = (op == OP_LW) || (op == OP_SW);
    assign is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);

    // Address windows, expressed as offsets from each base so wrap-around stays out.
    assign dm_off     = M_alu_res - DM_BASE;
    assign tc0_off    = M_alu_res - TC0_BASE;
    assign tc1_off    = M_alu_res - TC1_BASE;
    assign ig_off     = M_alu_res - IG_BASE;
    assign in_dm      = dm_off <= (DM_END - DM_BASE);
    assign in_tc0     = tc0_off < 32'(TC_WIN);
    assign in_tc1     = tc1_off < 32'(TC_WIN);
    assign in_ig      = ig_off < 32'(IG_WIN);
    assign in_timer   = in_tc0 || in_tc1;
    assign valid_addr = in_dm || in_timer || in_ig;
    assign tc_count   = (in_tc0 && (tc0_off[3:2] == 2'b10)) ||
                        (in_tc1 && (tc1_off[3:2] == 2'b10));

    assign misaligned = (is_word && (off != 2'b00)) || (is_half && off[0]);

    // Timers only accept full-word accesses, and their COUNT register is read-only.
    assign adel = is_load && (misaligned || M_ov || !valid_addr ||
                              (in_timer && (op != OP_LW)));
    assign ades = is_store && (misaligned || M_ov || !valid_addr ||
                               (in_timer && (op != OP_SW)) || tc_count);

    assign m_data_addr = M_alu_res;
    assign M_excode    = adel ? EXC_ADEL : (ades ? EXC_ADES : EXC_NONE);

    // Store byte enables and lane-replicated write data; faulting or flushed stores are masked.
    always_comb begin
        m_data_byteen = 4'b0000;
        m_data_wdata  = M_rt_data;
        case (op)
            OP_SW: m_data_byteen = 4'b1111;
            OP_SH: begin
                m_data_byteen = 4'b0011 << off;
                m_data_wdata  = {2{M_rt_data[15:0]}};
            end
            OP_SB: begin
                m_data_byteen = 4'b0001 << off;
                m_data_wdata  = {4{M_rt_data[7:0]}};
            end
            default: ;
        endcase
        if (ades || req) begin
            m_data_byteen = 4'b0000;
        end
    end

    // Select and extend the addressed byte/halfword of the read word.
    always_comb begin
        logic [7:0]  sel_b;
        logic [15:0] sel_h;
        sel_b    = m_data_rdata[7:0];
        sel_h    = off[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
        ext_data = m_data_rdata;
        case (off)
            2'd0:    sel_b = m_data_rdata[7:0];
            2'd1:    sel_b = m_data_rdata[15:8];
            2'd2:    sel_b = m_data_rdata[23:16];
            default: sel_b = m_data_rdata[31:24];
        endcase
        case (op)
            OP_LB:   ext_data = {{24{sel_b[7]}}, sel_b};
            OP_LBU:  ext_data = {24'h0, sel_b};
            OP_LH:   ext_data = {{16{sel_h[15]}}, sel_h};
            OP_LHU:  ext_data = {16'h0, sel_h};
            default: ext_data = m_data_rdata;
        endcase
    end

    // Next M/W contents: a CP0 request turns the slot into a bubble that keeps only the PC.
    always_comb begin
        w_pc_d  = M_PC;
        w_ins_d = M_ins;
        w_alu_d = M_alu_res;
        w_mlu_d = M_mlu_res;
        w_mem_d = ext_data;
        w_cp0_d = M_cp0_rd;
        if (req) begin
            w_ins_d = 32'h0;
            w_alu_d = 32'h0;
            w_mlu_d = 32'h0;
            w_mem_d = 32'h0;
            w_cp0_d = 32'h0;
        end
    end

    // M/W pipeline register; reset takes priority over the bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_pc_q  <= 32'h0;
            w_ins_q <= 32'h0;
            w_alu_q <= 32'h0;
            w_mlu_q <= 32'h0;
            w_mem_q <= 32'h0;
            w_cp0_q <= 32'h0;
        end else begin
            w_pc_q  <= w_pc_d;
            w_ins_q <= w_ins_d;
            w_alu_q <= w_alu_d;
            w_mlu_q <= w_mlu_d;
            w_mem_q <= w_mem_d;
            w_cp0_q <= w_cp0_d;
        end
    end

    assign W_PC       = w_pc_q;
    assign W_ins      = w_ins_q;
    assign W_alu_res  = w_alu_q;
    assign W_mlu_res  = w_mlu_q;
    assign W_mem_read = w_mem_q;
    assign W_cp0_rd   = w_cp0_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed store/address checks plus a W-stage scoreboard.
module tb_mem_stage;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_ADD = 6'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC, M_ins, M_alu_res, M_mlu_res, M_rt_data, M_cp0_rd, m_data_rdata;
    logic        M_ov, req;
    logic [31:0] m_data_addr, m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [4:0]  M_excode;
    logic [31:0] W_PC, W_ins, W_alu_res, W_mlu_res, W_mem_read, W_cp0_rd;

    typedef struct {
        logic [31:0] pc, ins, alu, mlu, mem, cp0;
        logic        chk_mem;
        string       tag;
    } w_exp_t;

    w_exp_t exp_q[$];
    int     n_checks = 0;
    int     n_fails  = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .M_PC(M_PC), .M_ins(M_ins), .M_alu_res(M_alu_res), .M_mlu_res(M_mlu_res),
        .M_rt_data(M_rt_data), .M_ov(M_ov), .M_cp0_rd(M_cp0_rd), .req(req),
        .m_data_rdata(m_data_rdata),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .M_excode(M_excode),
        .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res), .W_mlu_res(W_mlu_res),
        .W_mem_read(W_mem_read), .W_cp0_rd(W_cp0_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference load extension, written from the byte-lane view.
    function automatic logic [31:0] model_ext(input logic [5:0] op, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * int'(off));
        case (op)
            OP_LB:   return {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  return 32'(sh[7:0]);
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return 32'(sh[15:0]);
            default: return rd;
        endcase
    endfunction

    // Drive one M-stage slot and queue what W must show one cycle later.
    task automatic apply(input string tag, input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] rt, input logic [31:0] rd,
                         input logic ov, input logic rq, input logic rst);
        w_exp_t e;
        reset        = rst;
        req          = rq;
        M_ov         = ov;
        M_PC         = pc;
        M_ins        = {op, 5'd3, 5'd4, 16'h0010};
        M_alu_res    = a;
        M_rt_data    = rt;
        m_data_rdata = rd;
        M_mlu_res    = $urandom;
        M_cp0_rd     = $urandom;
        e.tag     = tag;
        e.chk_mem = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                    (op == OP_LB) || (op == OP_LBU) || rq || rst;
        if (rst) begin
            e.pc = 0; e.ins = 0; e.alu = 0; e.mlu = 0; e.mem = 0; e.cp0 = 0;
        end else if (rq) begin
            e.pc = pc; e.ins = 0; e.alu = 0; e.mlu = 0; e.mem = 0; e.cp0 = 0;
        end else begin
            e.pc = pc; e.ins = M_ins; e.alu = a; e.mlu = M_mlu_res;
            e.mem = model_ext(op, a[1:0], rd); e.cp0 = M_cp0_rd;
        end
        exp_q.push_back(e);
        #1;
    endtask

    // Advance one clock and compare the W register against the oldest queued entry.
    task automatic tick();
        w_exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, ".W_PC"}, W_PC, e.pc);
        check({e.tag, ".W_ins"}, W_ins, e.ins);
        check({e.tag, ".W_alu_res"}, W_alu_res, e.alu);
        check({e.tag, ".W_mlu_res"}, W_mlu_res, e.mlu);
        check({e.tag, ".W_cp0_rd"}, W_cp0_rd, e.cp0);
        if (e.chk_mem) check({e.tag, ".W_mem_read"}, W_mem_read, e.mem);
    endtask

    task automatic comb(input string tag, input logic [3:0] be, input logic [4:0] exc);
        check({tag, ".byteen"}, 32'(m_data_byteen), 32'(be));
        check({tag, ".excode"}, 32'(M_excode), 32'(exc));
    endtask

    initial begin
        logic [5:0]  lop;
        logic [31:0] la;
        logic [5:0]  ops [5];
        ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};

        // Reset holds W at zero.
        apply("rst0", OP_SW, 32'h3000, 32'h10, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        apply("rst1", OP_LW, 32'h3004, 32'h14, 32'h1, 32'h5, 1'b0, 1'b0, 1'b1);
        tick();

        apply("sb103", OP_SB, 32'h3000, 32'h0000_0103, 32'h1234_56AB, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sb103", 4'b1000, 5'd0);
        check("sb103.wdata", m_data_wdata, 32'hABAB_ABAB);
        check("sb103.addr", m_data_addr, 32'h0000_0103);
        tick();

        apply("sh102", OP_SH, 32'h3004, 32'h0000_0102, 32'hCAFE_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sh102", 4'b1100, 5'd0);
        check("sh102.wdata", m_data_wdata, 32'hBEEF_BEEF);
        tick();

        apply("lb", OP_LB, 32'h3008, 32'h0000_0102, 32'h0, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
        comb("lb", 4'b0000, 5'd0);
        tick();
        check("lb.value", W_mem_read, 32'hFFFF_FF80);
        apply("lbu", OP_LBU, 32'h300C, 32'h0000_0102, 32'h0, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
        tick();
        check("lbu.value", W_mem_read, 32'h0000_0080);
        apply("lh2", OP_LH, 32'h3010, 32'h0000_0202, 32'h0, 32'h9ABC_1234, 1'b0, 1'b0, 1'b0);
        tick();
        check("lh2.value", W_mem_read, 32'hFFFF_9ABC);

        apply("lw_mis", OP_LW, 32'h3014, 32'h0000_0006, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("lw_mis", 4'b0000, 5'd4);
        tick();
        apply("sw_count", OP_SW, 32'h3018, 32'h0000_7F08, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_count", 4'b0000, 5'd5);
        tick();
        apply("sw_tc1cnt", OP_SW, 32'h301C, 32'h0000_7F18, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_tc1cnt", 4'b0000, 5'd5);
        tick();
        apply("sw_tc1ctl", OP_SW, 32'h3020, 32'h0000_7F14, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_tc1ctl", 4'b1111, 5'd0);
        tick();
        apply("lh_timer", OP_LH, 32'h3024, 32'h0000_7F00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("lh_timer", 4'b0000, 5'd4);
        tick();
        apply("lw_count", OP_LW, 32'h3028, 32'h0000_7F08, 32'h0, 32'h7, 1'b0, 1'b0, 1'b0);
        comb("lw_count", 4'b0000, 5'd0);
        tick();
        apply("sw_hole", OP_SW, 32'h302C, 32'h0000_4000, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_hole", 4'b0000, 5'd5);
        tick();
        apply("sw_ig", OP_SW, 32'h3030, 32'h0000_7F20, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_ig", 4'b1111, 5'd0);
        tick();
        apply("sw_ig_end", OP_SW, 32'h3034, 32'h0000_7F24, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("sw_ig_end", 4'b0000, 5'd5);
        tick();
        apply("lw_dm_end", OP_LW, 32'h3038, 32'h0000_2FFC, 32'h0, 32'h55, 1'b0, 1'b0, 1'b0);
        comb("lw_dm_end", 4'b0000, 5'd0);
        tick();
        apply("lw_dm_out", OP_LW, 32'h303C, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("lw_dm_out", 4'b0000, 5'd4);
        tick();
        apply("lw_ov", OP_LW, 32'h3040, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        comb("lw_ov", 4'b0000, 5'd4);
        tick();
        apply("nonmem", OP_ADD, 32'h3044, 32'h0000_0006, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        comb("nonmem", 4'b0000, 5'd0);
        tick();

        // Flushed store: no write, W becomes a bubble carrying the PC.
        apply("sw_req", OP_SW, 32'h3048, 32'h0000_0020, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
        comb("sw_req", 4'b0000, 5'd0);
        tick();

        // Reset beats req; the first clean cycle passes the PC through.
        apply("rst_req", OP_SW, 32'h304C, 32'h0000_0020, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1);
        comb("rst_req", 4'b0000, 5'd0);
        tick();
        apply("post_rst", OP_ADD, 32'h0000_3000, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_rst.pc", W_PC, 32'h0000_3000);

        // Random in-range aligned loads through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            lop = ops[$urandom_range(0, 4)];
            la  = 32'($urandom_range(0, 32'h2FFF));
            if (lop == OP_LW) la[1:0] = 2'b00;
            else if (lop == OP_LH || lop == OP_LHU) la[0] = 1'b0;
            apply($sformatf("rnd%0d", i), lop, 32'h4000 + 32'(4 * i), la, 32'h0, $urandom,
                  1'b0, 1'b0, 1'b0);
            comb($sformatf("rnd%0d", i), 4'b0000, 5'd0);
            tick();
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage plus the M/W pipeline register of the five-stage MIPS pipeline with CP0.
- Combinationally drives the data-memory/bridge store interface: address, byte enables and aligned write data.
- Checks load/store addresses and reports AdEL/AdES to CP0.
- Sign/zero-extends load data, then registers everything the writeback stage consumes: W_PC, W_ins, alu_res, mlu_res, mem_read, cp0_rd.

Parameters:
- DM_BASE, 32'h0000_0000, first byte of data memory
- DM_END, 32'h0000_2FFF, last byte of data memory
- TC0_BASE, 32'h0000_7F00, timer 0 base; 12-byte window
- TC1_BASE, 32'h0000_7F10, timer 1 base; 12-byte window
- IG_BASE, 32'h0000_7F20, interrupt generator base; 4-byte window

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- M_PC  in  32  PC of instruction in M
- M_ins  in  32  instruction word in M
- M_alu_res  in  32  ALU result; the effective address for loads/stores
- M_mlu_res  in  32  HI/LO read result
- M_rt_data  in  32  forwarded rt value (store data)
- M_ov  in  1  effective-address calculation overflowed in E
- M_cp0_rd  in  32  CP0 read data
- req  in  1  CP0 exception/interrupt request this cycle
- m_data_rdata  in  32  bridge read data; combinational from m_data_addr
- m_data_addr  out  32  = M_alu_res
- m_data_wdata  out  32  aligned store data
- m_data_byteen  out  4  store byte enables
- M_excode  out  5  0 = none, 4 = AdEL, 5 = AdES
- W_PC, W_ins, W_alu_res, W_mlu_res, W_mem_read, W_cp0_rd  out  32 each  registered W-stage values

Behaviour:
- Decode by opcode, M_ins[31:26]:
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Anything else is a non-memory instruction: byteen 0, excode 0.
- Let A = M_alu_res; off = A[1:0].
- Store byte enables:
  - sw → 4'b1111.
  - sh → 4'b0011 << off (off ∈ {0,2}).
  - sb → 4'b0001 << off.
- Store data:
  - sw → rt.
  - sh → rt[15:0] replicated ×2.
  - sb → rt[7:0] replicated ×4.
- Valid address: inside [DM_BASE,DM_END], TC0 window, TC1 window or IG window.
- AdEL (load) when any of:
  - misaligned (lw off≠0, lh/lhu off[0]≠0);
  - M_ov;
  - address outside every valid range;
  - lh/lhu/lb/lbu targeting a timer window.
- AdES (store) when any of:
  - misaligned (sw off≠0, sh off[0]≠0);
  - M_ov;
  - address outside every valid range;
  - sh/sb targeting a timer window;
  - any store to a timer COUNT register (offset 8).
- m_data_byteen is forced 4'b0000 when AdES or req=1. A faulting or flushed store never writes.
- Load extension is combinational from m_data_rdata and off:
  - lb selects byte off, sign-extended; lbu selects the same byte, zero-extended.
  - lh selects halfword off[1], sign-extended; lhu selects the same halfword, zero-extended.
  - lw passes the word through.
  - The result is registered into W_mem_read.
- M/W register, updated every posedge; this stage never stalls:
  - reset=1 → all six W outputs become 0.
  - else if req=1 → W_ins, W_alu_res, W_mlu_res, W_mem_read, W_cp0_rd become 0 (bubble, sll $0), and W_PC becomes M_PC.
  - else → each W output becomes its M-side value; W_mem_read becomes the extended load data.
- Latency: one cycle from M inputs to W outputs. m_data_* and M_excode are same-cycle combinational.
- Simultaneous reset and req: reset wins.
- Reset mid-store: byteen still follows the combinational rules that cycle. The bridge ignores writes while reset is high.

Test Plan:
- sb, A=0x0000_0103, rt=0x1234_56AB → byteen 4'b1000, wdata 0xABABABAB, excode 0.
- lb, A=0x0000_0102, rdata=0x0080_0000 → next cycle W_mem_read 0xFFFF_FF80. Repeat with lbu → 0x0000_0080.
- lw, A=0x0000_0006 → excode 4. sw, A=0x0000_7F08 → excode 5, byteen 0. lh, A=0x0000_7F00 → excode 4.
- sw, A=0x0000_4000 → excode 5, byteen 0. sw, A=0x0000_7F20 → excode 0, byteen 4'hF.
- sw valid with req=1 → byteen 0. Next cycle W_ins 0, W_PC = M_PC, W_alu_res 0.
- reset asserted with req=1 and valid data in M → next cycle all W outputs 0. First non-reset cycle passes M_PC=0x3000 through to W_PC.
